// File: rtl/mips_multicycle_ctrl_pkg.sv
// rtl/mips_multicycle_ctrl_pkg.sv - states, opcodes and control encodings for the multi-cycle MIPS controller
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_HALT     = 4'd11,
        S_ADDI_EX  = 4'd12,
        S_ADDI_WB  = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctl_t;

    // States that wait on the memory handshake and are guarded by the timeout.
    function automatic logic is_mem_state(state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - controller-to-datapath signal bundle
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       error;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               error, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               error, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl_outdec.sv
// rtl/mips_multicycle_ctrl_outdec.sv - combinational decode of state, zero and mem_ready into control outputs
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_e state_i,
    input  logic   zero_i,
    input  logic   mem_ready_i,
    output ctl_t   ctl_o
);

    always_comb begin
        ctl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctl_o.mem_read  = 1'b1;
                ctl_o.alu_src_b = SRCB_FOUR;
                ctl_o.alu_op    = ALU_ADD;
                ctl_o.pc_source = PCSRC_ALU;
                // IR and PC load only on the cycle the instruction word arrives.
                ctl_o.ir_write  = mem_ready_i;
                ctl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctl_o.alu_src_b = SRCB_IMM_SH;
                ctl_o.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ctl_o.alu_src_a = 1'b1;
                ctl_o.alu_src_b = SRCB_IMM;
                ctl_o.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctl_o.mem_read = 1'b1;
                ctl_o.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctl_o.reg_write  = 1'b1;
                ctl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctl_o.mem_write = 1'b1;
                ctl_o.iord      = 1'b1;
            end
            S_EXEC_R: begin
                ctl_o.alu_src_a = 1'b1;
                ctl_o.alu_src_b = SRCB_REG;
                ctl_o.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctl_o.reg_write = 1'b1;
                ctl_o.reg_dst   = 1'b1;
            end
            S_ADDI_WB: ctl_o.reg_write = 1'b1;
            S_BRANCH: begin
                ctl_o.alu_src_a = 1'b1;
                ctl_o.alu_src_b = SRCB_REG;
                ctl_o.alu_op    = ALU_SUB;
                ctl_o.pc_source = PCSRC_ALUOUT;
                ctl_o.pc_write  = zero_i;
            end
            S_JUMP: begin
                ctl_o.pc_write  = 1'b1;
                ctl_o.pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM with memory-wait timeout; MIPS_CTRL_ADDI_EN enables addi
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mips_multicycle_ctrl_if.master bus
);

    localparam bit         TMO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [3:0] TMO_LAST = 4'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       error_q, error_d;
    ctl_t       ctl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        error_d = error_q;
        wait_d  = '0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EX;
`endif
                    default: begin
                        state_d = S_HALT;
                        error_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC_R:   state_d = S_R_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_IDLE;
        endcase

        // The counter only survives while a memory state keeps waiting; any exit clears it.
        if (is_mem_state(state_q) && !bus.mem_ready) begin
            if (TMO_EN && (wait_q == TMO_LAST)) begin
                state_d = S_HALT;
                error_d = 1'b1;
            end else begin
                wait_d = (wait_q == 4'hF) ? wait_q : wait_q + 4'd1;
            end
        end
    end

    mips_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .zero_i      (bus.zero),
        .mem_ready_i (bus.mem_ready),
        .ctl_o       (ctl)
    );

    assign bus.pc_write   = ctl.pc_write;
    assign bus.ir_write   = ctl.ir_write;
    assign bus.iord       = ctl.iord;
    assign bus.mem_read   = ctl.mem_read;
    assign bus.mem_write  = ctl.mem_write;
    assign bus.mem_to_reg = ctl.mem_to_reg;
    assign bus.reg_dst    = ctl.reg_dst;
    assign bus.reg_write  = ctl.reg_write;
    assign bus.alu_src_a  = ctl.alu_src_a;
    assign bus.alu_src_b  = ctl.alu_src_b;
    assign bus.alu_op     = ctl.alu_op;
    assign bus.pc_source  = ctl.pc_source;
    assign bus.error      = error_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for the multi-cycle MIPS controller
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {pcw, irw, iord, mrd, mwr, m2r, rdst, rwr, srca, srcb[2], aluop[2], pcsrc[2]}
    localparam logic [14:0] C_ZERO    = 15'b0_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [14:0] C_FETCH_W = 15'b0_0_0_1_0_0_0_0_0_01_00_00;
    localparam logic [14:0] C_FETCH_R = 15'b1_1_0_1_0_0_0_0_0_01_00_00;
    localparam logic [14:0] C_DECODE  = 15'b0_0_0_0_0_0_0_0_0_11_00_00;
    localparam logic [14:0] C_MADDR   = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
    localparam logic [14:0] C_MEMRD   = 15'b0_0_1_1_0_0_0_0_0_00_00_00;
    localparam logic [14:0] C_MEMWB   = 15'b0_0_0_0_0_1_0_1_0_00_00_00;
    localparam logic [14:0] C_MEMWR   = 15'b0_0_1_0_1_0_0_0_0_00_00_00;
    localparam logic [14:0] C_EXECR   = 15'b0_0_0_0_0_0_0_0_1_00_10_00;
    localparam logic [14:0] C_RWB     = 15'b0_0_0_0_0_0_1_1_0_00_00_00;
    localparam logic [14:0] C_BR_T    = 15'b1_0_0_0_0_0_0_0_1_00_01_01;
    localparam logic [14:0] C_BR_N    = 15'b0_0_0_0_0_0_0_0_1_00_01_01;
    localparam logic [14:0] C_JUMP    = 15'b1_0_0_0_0_0_0_0_0_00_00_10;
    localparam logic [14:0] C_ADDIWB  = 15'b0_0_0_0_0_0_0_1_0_00_00_00;

    typedef struct packed {
        logic [15:0] id;
        logic [3:0]  st;
        logic [14:0] ctl;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   sid   = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic step(input logic rn, input logic [5:0] op, input logic z, input logic rdy,
                        input logic [3:0] st, input logic [14:0] ctl, input logic err);
        @(posedge clk);
        #1;
        rst_n         = rn;
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = rdy;
        exp_q.push_back(exp_t'{16'(sid), st, ctl, err});
        sid++;
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [14:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {bus.pc_write, bus.ir_write, bus.iord, bus.mem_read, bus.mem_write,
                   bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                   bus.alu_src_b, bus.alu_op, bus.pc_source};
            total++;
            if (bus.state !== e.st || act !== e.ctl || bus.error !== e.err) begin
                bad++;
                $display("FAIL step%0d: state=%0d ctl=%b error=%b, expected state=%0d ctl=%b error=%b",
                         e.id, bus.state, act, bus.error, e.st, e.ctl, e.err);
            end
        end
    end

    initial begin
        bus.opcode    = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        step(0, OP_LW, 0, 1, S_IDLE, C_ZERO, 0);
        step(0, OP_LW, 1, 1, S_IDLE, C_ZERO, 0);
        step(1, OP_LW, 0, 1, S_IDLE, C_ZERO, 0);

        // lw, zero-wait memory
        step(1, OP_LW, 0, 1, S_FETCH,    C_FETCH_R, 0);
        step(1, OP_LW, 0, 0, S_DECODE,   C_DECODE,  0);
        step(1, OP_LW, 0, 1, S_MEM_ADDR, C_MADDR,   0);
        step(1, OP_LW, 0, 1, S_MEM_RD,   C_MEMRD,   0);
        step(1, OP_LW, 0, 1, S_MEM_WB,   C_MEMWB,   0);

        // sw with three wait cycles in MEM_WR
        step(1, OP_SW, 0, 1, S_FETCH,    C_FETCH_R, 0);
        step(1, OP_SW, 0, 1, S_DECODE,   C_DECODE,  0);
        step(1, OP_SW, 0, 0, S_MEM_ADDR, C_MADDR,   0);
        for (int i = 0; i < 3; i++) step(1, OP_SW, 0, 0, S_MEM_WR, C_MEMWR, 0);
        step(1, OP_SW, 0, 1, S_MEM_WR,   C_MEMWR,   0);

        // R-type
        step(1, OP_RTYPE, 0, 1, S_FETCH,  C_FETCH_R, 0);
        step(1, OP_RTYPE, 0, 1, S_DECODE, C_DECODE,  0);
        step(1, OP_RTYPE, 0, 1, S_EXEC_R, C_EXECR,   0);
        step(1, OP_RTYPE, 0, 1, S_R_WB,   C_RWB,     0);

        // beq taken then not taken
        step(1, OP_BEQ, 0, 1, S_FETCH,  C_FETCH_R, 0);
        step(1, OP_BEQ, 0, 1, S_DECODE, C_DECODE,  0);
        step(1, OP_BEQ, 1, 1, S_BRANCH, C_BR_T,    0);
        step(1, OP_BEQ, 1, 1, S_FETCH,  C_FETCH_R, 0);
        step(1, OP_BEQ, 1, 1, S_DECODE, C_DECODE,  0);
        step(1, OP_BEQ, 0, 1, S_BRANCH, C_BR_N,    0);

        // j with one fetch wait
        step(1, OP_J, 0, 0, S_FETCH,  C_FETCH_W, 0);
        step(1, OP_J, 0, 1, S_FETCH,  C_FETCH_R, 0);
        step(1, OP_J, 0, 1, S_DECODE, C_DECODE,  0);
        step(1, OP_J, 0, 1, S_JUMP,   C_JUMP,    0);

        // addi: legal only with the feature enabled
        step(1, OP_ADDI, 0, 1, S_FETCH,  C_FETCH_R, 0);
        step(1, OP_ADDI, 0, 1, S_DECODE, C_DECODE,  0);
`ifdef MIPS_CTRL_ADDI_EN
        step(1, OP_ADDI, 0, 1, S_ADDI_EX, C_MADDR,   0);
        step(1, OP_ADDI, 0, 1, S_ADDI_WB, C_ADDIWB,  0);
        step(1, OP_ADDI, 0, 0, S_FETCH,   C_FETCH_W, 0);
        step(0, OP_ADDI, 0, 0, S_IDLE,    C_ZERO,    0);
`else
        step(1, OP_ADDI, 0, 1, S_HALT, C_ZERO, 1);
        step(1, OP_ADDI, 1, 1, S_HALT, C_ZERO, 1);
        step(0, OP_ADDI, 0, 1, S_IDLE, C_ZERO, 0);
`endif
        step(1, OP_LW, 0, 1, S_IDLE, C_ZERO, 0);

        // reset in the middle of lw aborts before MEM_RD
        step(1, OP_LW, 0, 1, S_FETCH,    C_FETCH_R, 0);
        step(1, OP_LW, 0, 1, S_DECODE,   C_DECODE,  0);
        step(1, OP_LW, 0, 1, S_MEM_ADDR, C_MADDR,   0);
        step(0, OP_LW, 0, 1, S_IDLE,     C_ZERO,    0);
        step(1, OP_LW, 0, 1, S_IDLE,     C_ZERO,    0);

        // illegal opcode halts with every enable low
        step(1, 6'h3F, 0, 1, S_FETCH,  C_FETCH_R, 0);
        step(1, 6'h3F, 0, 1, S_DECODE, C_DECODE,  0);
        for (int i = 0; i < 20; i++) step(1, 6'h3F, i[0], i[1], S_HALT, C_ZERO, 1);
        step(0, 6'h3F, 0, 1, S_IDLE, C_ZERO, 0);
        step(1, OP_RTYPE, 0, 0, S_IDLE, C_ZERO, 0);

        // fetch timeout after four wait cycles
        for (int i = 0; i < 4; i++) step(1, OP_RTYPE, 0, 0, S_FETCH, C_FETCH_W, 0);
        for (int i = 0; i < 3; i++) step(1, OP_RTYPE, 1, 1, S_HALT, C_ZERO, 1);
        step(0, OP_RTYPE, 0, 0, S_IDLE, C_ZERO, 0);
        step(1, OP_RTYPE, 0, 1, S_IDLE, C_ZERO, 0);
        step(1, OP_RTYPE, 0, 1, S_FETCH,  C_FETCH_R, 0);
        step(1, OP_RTYPE, 0, 1, S_DECODE, C_DECODE,  0);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control FSM that sequences the MIPS processor datapath (register file, ALU, memory, PC/IR) through fetch, decode, execute, memory and write-back. It replaces per-instruction combinational control with a Moore state machine. Memory accesses use a ready handshake, so variable-latency memory is supported. It supports lw, sw, R-type, beq and j; any other opcode halts the core with a sticky error flag.

## Interface
Parameters:
- MEM_TIMEOUT, default 15: maximum cycles to wait for mem_ready before flagging an error; 0 disables the timeout.

Ports (clock and reset first):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- opcode  input  6  instruction[31:26] from the IR
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory has completed the current access this cycle
- pc_write  output  1  load the PC
- ir_write  output  1  load the IR
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- mem_to_reg  output  1  write-back source: 1 = MDR, 0 = ALUOut
- reg_dst  output  1  write-register select: 1 = rd, 0 = rt
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A operand: 0 = PC, 1 = A
- alu_src_b  output  2  ALU B operand: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  output  2  00 = add, 01 = sub, 10 = decode funct
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- error  output  1  sticky: illegal opcode or memory timeout
- state  output  4  current state, for debug

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, BRANCH, JUMP, HALT.
- IDLE:
  - Reset state; all outputs 0.
  - Goes to FETCH unconditionally on the next edge.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target).
  - Next state by opcode: 0x23/0x2B → MEM_ADDR; 0x00 → EXEC_R; 0x04 → BRANCH; 0x02 → JUMP; anything else → HALT with error set.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state: lw → MEM_RD, sw → MEM_WR.
- MEM_RD: mem_read=1, iord=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
- MEM_WR:
  - mem_write=1, iord=1.
  - Waits for mem_ready, then goes to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_WB.
- R_WB: reg_write=1, mem_to_reg=0, reg_dst=1. Next state FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01.
  - pc_write = zero.
  - Next state FETCH.
- JUMP: pc_write=1, pc_source=10. Next state FETCH.
- HALT: all enables 0; remains in HALT until rst_n is asserted.
- Opcode is sampled only in DECODE and MEM_ADDR. The IR holds it stable from the end of FETCH.
- Memory timeout: a 4-bit wait counter clears on entry to FETCH, MEM_RD or MEM_WR and increments each cycle mem_ready=0. When it reaches MEM_TIMEOUT the FSM goes to HALT and sets error.

## Timing
- Reset: asynchronous and active-low. While rst_n=0: state=IDLE, error=0, wait counter=0, every output 0.
- First FETCH request appears 1 cycle after reset release.
- Outputs are Moore, decoded from the state register, except:
  - pc_write in BRANCH depends on zero;
  - ir_write/pc_write in FETCH depend on mem_ready.
- Latency with zero-wait memory (mem_ready=1 on the first cycle of each access): lw 5, sw 4, R-type 4, beq 3, j 3 cycles, counted from FETCH entry to the next FETCH entry.
- Each cycle mem_ready=0 in FETCH/MEM_RD/MEM_WR adds one cycle.
- mem_ready outside the memory states is ignored.
- mem_read and mem_write are never asserted in the same cycle.
- Reset asserted mid-instruction aborts it immediately. No partial register write follows, since all outputs go to 0.

## Configuration
- MIPS_CTRL_ADDI_EN:
  - When defined, opcode 0x08 (addi) is legal and adds states ADDI_EX and ADDI_WB.
  - ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
  - addi latency is 4 cycles.
  - When undefined, opcode 0x08 is illegal and goes to HALT with error set.

## Structure
- Package mips_ctrl_pkg holds:
  - the state enum;
  - opcode constants OP_RTYPE=0x00, OP_J=0x02, OP_BEQ=0x04, OP_ADDI=0x08, OP_LW=0x23, OP_SW=0x2B;
  - alu_op, alu_src_b and pc_source encodings.
- One sub-module, mips_ctrl_outdec: purely combinational decode from state, zero and mem_ready to the control outputs. The FSM and wait counter stay in the top module.

## Test plan
- Reset, then lw with mem_ready held at 1 → states IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, FETCH; reg_write=1 and mem_to_reg=1 in MEM_WB only.
- sw with mem_ready low for 3 cycles in MEM_WR → mem_write high for 4 cycles; no reg_write; returns to FETCH.
- beq with zero=1, then beq with zero=0 → pc_write=1 with pc_source=01 in the first BRANCH; pc_write=0 in the second.
- Opcode 0x3F → HALT, error=1, all enables 0 for 20 cycles; rst_n pulse clears error and returns to IDLE.
- MEM_TIMEOUT=4 with mem_ready stuck at 0 in FETCH → HALT and error=1 after 4 wait cycles.
- Opcode 0x08 with MIPS_CTRL_ADDI_EN defined → ADDI_EX, ADDI_WB, FETCH. Same opcode without the macro → HALT, error=1.
